dm_arbiter: RTL
===============

// Module: dm_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer for the single-port data memory (DM: registered read, 1-cycle latency).
//  Port 0 = pipeline MEM stage; port 1 = auxiliary master (program loader / debug DMA).
//  Fixed priority to port 0 with a starvation guard for port 1; drives DM addr/din/r/w, routes read data back, raises stall.
// PARAMETERS
//  AW            32  address width (byte address; DM uses word index [6:2])
//  DW            32  data width
//  STARVE_LIMIT  4   consecutive cycles port 1 may be denied before it is forced through (1..255)
// PORTS
//  clk        in   1   rising-edge clock, same clock as DM
//  rst        in   1   synchronous, active-high reset
//  p0_req     in   1   port 0 access request (level, held until granted)
//  p0_we      in   1   port 0 write (1) / read (0)
//  p0_addr    in   AW  port 0 byte address
//  p0_wdata   in   DW  port 0 write data
//  p0_gnt     out  1   port 0 granted this cycle (comb.)
//  p0_rvalid  out  1   port 0 read data valid (registered)
//  p0_rdata   out  DW  port 0 read data
//  p0_stall   out  1   p0_req & ~p0_gnt; freezes IF/ID/EX/MEM
//  p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: as port 0, for port 1
//  dm_addr    out  AW  to DM data_address
//  dm_din     out  DW  to DM data_in
//  dm_r       out  1   to DM dm_r (`DM_R_ON when granted read)
//  dm_w       out  1   to DM dm_w (`DM_W_ON when granted write)
//  dm_dout    in   DW  from DM data_out (valid cycle after read grant)
// BEHAVIOUR
//  - Reset: gnt/rvalid/stall 0, dm_r=dm_w=off, dm_addr/dm_din 0, starve_cnt 0, rd_owner NONE. rst forces all outputs
//    off in the same cycle (comb. outputs gated by rst).
//  - Grant (comb., one grant max per cycle): force1 = (starve_cnt == STARVE_LIMIT).
//    p1 wins if p1_req & (~p0_req | force1); else p0 wins if p0_req. No request -> no grant, dm_r/dm_w off.
//  - DM drive: mux of winner's addr/wdata; dm_w = winner_we, dm_r = ~winner_we. Idle: addr/din hold 0.
//  - starve_cnt: +1 when p1_req & ~p1_gnt (saturate at STARVE_LIMIT); cleared on p1_gnt or ~p1_req.
//  - Read return: on a read grant, rd_owner <= winner; next cycle px_rvalid=1 for exactly one cycle,
//    px_rdata = dm_dout. Non-owner rdata holds last value; rvalid 0. Back-to-back reads -> rvalid every cycle.
//  - Writes: complete at the grant edge; no rvalid. Read after write to same addr in next cycle returns new data.
//  - Simultaneous p0/p1 to same address: serialised by priority; no merging.
//  - Requester contract: req/we/addr/wdata stable while req & ~gnt; checked by assertion, not corrected.
//  - Reset mid-read: pending rvalid squashed; rd_owner NONE; dm_dout ignored.
//  - Latency: grant 0 cycles (same cycle as req if uncontended); read data 1 cycle after grant.
// STRUCTURE
//  - Use DM_R_ON/DM_W_ON/off encodings from ctrl_encode_def.v; add there:
//    DMARB_OWNER_NONE/P0/P1 (2-bit) and DMARB_STARVE_DEF.
//  - One sub-module natural: dm_arb_starve_ctr (saturating counter, clr/inc, reaches-limit flag).
//  - Grant/mux logic combinational; rd_owner, rvalid, starve_cnt registered.
// TESTING
//  1 Reset: rst=1 with both req=1 -> no gnt, dm_r=dm_w=0, rvalid=0; release -> p0 granted same cycle.
//  2 p0 write 0x0000_0010 <= 0xDEADBEEF, then p0 read 0x10 -> p0_rvalid next cycle, p0_rdata=0xDEADBEEF.
//  3 Both req continuously, STARVE_LIMIT=4 -> p0 granted 4 cycles, p1 on 5th (p0_stall=1 there), repeat.
//  4 p0 read 0x20 then p1 read 0x24 back-to-back -> p0_rvalid, then p1_rvalid, correct data, no cross-routing.
//  5 rst asserted cycle after read grant -> no rvalid on either port; counter 0.
//  6 p1 only, write 0x04 <= 0x1234 -> p1_gnt same cycle, p0_stall=0, DM[1]=0x1234.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: DM strobe levels,
// read-owner tags and the default starvation limit.
package dm_arbiter_pkg;

  localparam logic DM_R_ON  = 1'b1;
  localparam logic DM_R_OFF = 1'b0;
  localparam logic DM_W_ON  = 1'b1;
  localparam logic DM_W_OFF = 1'b0;

  typedef enum logic [1:0] {
    DMARB_OWNER_NONE = 2'b00,
    DMARB_OWNER_P0   = 2'b01,
    DMARB_OWNER_P1   = 2'b10
  } dmarb_owner_e;

  localparam int unsigned DMARB_STARVE_DEF = 4;
  localparam int unsigned DMARB_CNT_W      = 8;

endpackage

// File: rtl/dm_arbiter_if.sv
// One requester port of the DM arbiter. The requester uses master, the
// arbiter uses slave.
interface dm_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          stall;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, stall);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, stall);
endinterface

// File: rtl/dm_arb_starve_ctr.sv
// Saturating counter of consecutive cycles port 1 has been denied.
// o_at_limit forces port 1 through on the next arbitration.
module dm_arb_starve_ctr
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = DMARB_STARVE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_inc,
  input  logic                   i_clr,
  output logic [DMARB_CNT_W-1:0] o_cnt,
  output logic                   o_at_limit
);
  localparam logic [DMARB_CNT_W-1:0] LIM = DMARB_CNT_W'(LIMIT);

  logic [DMARB_CNT_W-1:0] r_cnt;

  // count denied cycles, holding at LIMIT until port 1 is served or drops
  always_ff @(posedge clk) begin
    if (rst || i_clr)               r_cnt <= '0;
    else if (i_inc && r_cnt != LIM) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt      = r_cnt;
  assign o_at_limit = (r_cnt == LIM);
endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single-port data memory (registered read,
// 1-cycle latency). Port 0 (MEM stage) has priority; port 1 is forced
// through after STARVE_LIMIT consecutive denials. Grant and DM drive are
// combinational; read ownership and starvation count are registered.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int          AW           = 32,
  parameter int          DW           = 32,
  parameter int unsigned STARVE_LIMIT = DMARB_STARVE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  dm_arbiter_if.slave   p0,
  dm_arbiter_if.slave   p1,
  output logic [AW-1:0] o_dm_addr,
  output logic [DW-1:0] o_dm_din,
  output logic          o_dm_r,
  output logic          o_dm_w,
  input  logic [DW-1:0] i_dm_dout
);
  logic                   w_force1;
  logic                   w_p0_win;
  logic                   w_p1_win;
  logic                   w_p0_rvalid;
  logic                   w_p1_rvalid;
  logic [DMARB_CNT_W-1:0] w_starve_cnt;
  dmarb_owner_e           r_rd_owner;
  logic [DW-1:0]          r_p0_rdata;
  logic [DW-1:0]          r_p1_rdata;

  dm_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (p1.req & ~w_p1_win),
    .i_clr      (~p1.req | w_p1_win),
    .o_cnt      (w_starve_cnt),
    .o_at_limit (w_force1)
  );

  // pick at most one winner and steer its address/data onto the DM; reset gates everything off
  always_comb begin
    w_p1_win  = ~rst & p1.req & (~p0.req | w_force1);
    w_p0_win  = ~rst & p0.req & ~w_p1_win;
    o_dm_addr = '0;
    o_dm_din  = '0;
    o_dm_r    = DM_R_OFF;
    o_dm_w    = DM_W_OFF;
    if (w_p1_win) begin
      o_dm_addr = p1.addr;
      o_dm_din  = p1.wdata;
      o_dm_r    = p1.we ? DM_R_OFF : DM_R_ON;
      o_dm_w    = p1.we ? DM_W_ON  : DM_W_OFF;
    end else if (w_p0_win) begin
      o_dm_addr = p0.addr;
      o_dm_din  = p0.wdata;
      o_dm_r    = p0.we ? DM_R_OFF : DM_R_ON;
      o_dm_w    = p0.we ? DM_W_ON  : DM_W_OFF;
    end
  end

  // remember who issued this cycle's read so next cycle's dm_dout is routed to it
  always_ff @(posedge clk) begin
    if (rst)                     r_rd_owner <= DMARB_OWNER_NONE;
    else if (w_p1_win && !p1.we) r_rd_owner <= DMARB_OWNER_P1;
    else if (w_p0_win && !p0.we) r_rd_owner <= DMARB_OWNER_P0;
    else                         r_rd_owner <= DMARB_OWNER_NONE;
  end

  assign w_p0_rvalid = ~rst & (r_rd_owner == DMARB_OWNER_P0);
  assign w_p1_rvalid = ~rst & (r_rd_owner == DMARB_OWNER_P1);

  // each port keeps its last returned word while the other port is being served
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      if (w_p0_rvalid) r_p0_rdata <= i_dm_dout;
      if (w_p1_rvalid) r_p1_rdata <= i_dm_dout;
    end
  end

  assign p0.gnt    = w_p0_win;
  assign p1.gnt    = w_p1_win;
  assign p0.stall  = ~rst & p0.req & ~w_p0_win;
  assign p1.stall  = ~rst & p1.req & ~w_p1_win;
  assign p0.rvalid = w_p0_rvalid;
  assign p1.rvalid = w_p1_rvalid;
  assign p0.rdata  = w_p0_rvalid ? i_dm_dout : r_p0_rdata;
  assign p1.rdata  = w_p1_rvalid ? i_dm_dout : r_p1_rdata;

  // a waiting requester must hold its request unchanged until granted
  a_p0_hold: assert property (@(posedge clk) disable iff (rst)
    (p0.req && !p0.gnt) |=> (p0.req && $stable({p0.we, p0.addr, p0.wdata})));
  a_p1_hold: assert property (@(posedge clk) disable iff (rst)
    (p1.req && !p1.gnt) |=> (p1.req && $stable({p1.we, p1.addr, p1.wdata})));

endmodule
